rc4_phase_scheduler: RTL and testbench

- Top-level sequencer for the RC4 decryption datapath.
- Runs three sub-FSMs in strict order: S-array init, key schedule (KSA), then PRGA/decrypt. Each run uses the current secret_key.
- Owns the single-port 256x8 S memory and grants its address/data/wren to exactly one phase at a time.
- On a PRGA run that reports an invalid plaintext, advances secret_key and restarts from init (brute-force key search) until it finds a valid key or exhausts the range.

---
 rtl/rc4_phase_scheduler_if.sv | 61 ++++++
 rtl/rc4_phase_scheduler.sv | 161 ++++++++++++++++
 tb/tb_rc4_phase_scheduler.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rc4_phase_scheduler_if.sv
// Purpose : bundles the scheduler's control, phase-FSM and S-memory signals.
// Ports   : master = scheduler side (drives start pulses, S port, key, status);
//           slave  = environment side (phase FSMs, S memory, search control).
//           timeout exists only when RC4_PHASE_TIMEOUT_EN is defined.
interface rc4_phase_scheduler_if #(
  parameter int KEY_WIDTH = 24
);
  logic                 start;
  logic                 init_start;
  logic                 init_done;
  logic [7:0]           init_address;
  logic [7:0]           init_data;
  logic                 init_wren;
  logic                 ksa_start;
  logic                 ksa_done;
  logic [7:0]           ksa_address;
  logic [7:0]           ksa_data;
  logic                 ksa_wren;
  logic                 prga_start;
  logic                 prga_done;
  logic                 prga_valid;
  logic [7:0]           prga_address;
  logic [7:0]           prga_data;
  logic                 prga_wren;
  logic [7:0]           s_address;
  logic [7:0]           s_data;
  logic                 s_wren;
  logic [KEY_WIDTH-1:0] secret_key;
  logic                 busy;
  logic                 key_found;
  logic                 key_fail;
`ifdef RC4_PHASE_TIMEOUT_EN
  logic                 timeout;
`endif

  modport master (
`ifdef RC4_PHASE_TIMEOUT_EN
    output timeout,
`endif
    input  start,
    output init_start, input init_done, input init_address, input init_data, input init_wren,
    output ksa_start,  input ksa_done,  input ksa_address,  input ksa_data,  input ksa_wren,
    output prga_start, input prga_done, input prga_valid,
    input  prga_address, input prga_data, input prga_wren,
    output s_address, output s_data, output s_wren,
    output secret_key, output busy, output key_found, output key_fail
  );

  modport slave (
`ifdef RC4_PHASE_TIMEOUT_EN
    input  timeout,
`endif
    output start,
    input  init_start, output init_done, output init_address, output init_data, output init_wren,
    input  ksa_start,  output ksa_done,  output ksa_address,  output ksa_data,  output ksa_wren,
    input  prga_start, output prga_done, output prga_valid,
    output prga_address, output prga_data, output prga_wren,
    input  s_address, input s_data, input s_wren,
    input  secret_key, input busy, input key_found, input key_fail
  );
endinterface

// File: rtl/rc4_phase_scheduler.sv
// Purpose : RC4 brute-force sequencer: init -> KSA -> PRGA per key, S-port owner.
// Ports   : clk, reset (sync, active-high), bus (rc4_phase_scheduler_if.master).
// Timing  : each GO state costs one cycle; phase start fires 1 cycle after prior done.
// Option  : RC4_PHASE_TIMEOUT_EN adds a per-phase watchdog and the timeout output.
module rc4_phase_scheduler #(
  parameter int                   KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX   = KEY_WIDTH'(24'h3FFFFF)
`ifdef RC4_PHASE_TIMEOUT_EN
  ,
  parameter int                   TIMEOUT_CYCLES = 4096
`endif
) (
  input logic                   clk,
  input logic                   reset,
  rc4_phase_scheduler_if.master bus
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_GO,
    ST_INIT_WAIT,
    ST_KSA_GO,
    ST_KSA_WAIT,
    ST_PRGA_GO,
    ST_PRGA_WAIT,
    ST_NEXT_KEY,
    ST_FOUND,
    ST_FAIL
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [KEY_WIDTH-1:0] key;

`ifdef RC4_PHASE_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 12) ? $clog2(TIMEOUT_CYCLES + 1) : 12;
  logic [CW-1:0] wdog;
  logic          wdog_expired;
  logic          timeout_q;
  logic          timeout_set;

  // Expires on the last permitted WAIT cycle, so the FSM leaves WAIT after
  // exactly TIMEOUT_CYCLES cycles without a done.
  assign wdog_expired = (wdog == CW'(TIMEOUT_CYCLES - 1));
`endif

  // State register, key register and watchdog.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      key   <= '0;
    end else begin
      state <= state_nxt;
      // The KEY_MAX check precedes the increment, so the key never wraps.
      if (state == ST_NEXT_KEY && key != KEY_MAX) begin
        key <= key + KEY_WIDTH'(1);
      end
    end
  end

`ifdef RC4_PHASE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ST_INIT_WAIT || state == ST_KSA_WAIT || state == ST_PRGA_WAIT) begin
        wdog <= wdog + CW'(1);
      end else begin
        wdog <= '0;
      end
      if (timeout_set) begin
        timeout_q <= 1'b1;
      end
    end
  end
`endif

  // Next-state logic. Each done is looked at only in its own WAIT state, so
  // early or stale dones from other phases cannot advance the sequence.
  always_comb begin
    state_nxt = state;
`ifdef RC4_PHASE_TIMEOUT_EN
    timeout_set = 1'b0;
`endif
    case (state)
      ST_IDLE:      if (bus.start) state_nxt = ST_INIT_GO;
      ST_INIT_GO:   state_nxt = ST_INIT_WAIT;
      ST_INIT_WAIT: if (bus.init_done) state_nxt = ST_KSA_GO;
      ST_KSA_GO:    state_nxt = ST_KSA_WAIT;
      ST_KSA_WAIT:  if (bus.ksa_done) state_nxt = ST_PRGA_GO;
      ST_PRGA_GO:   state_nxt = ST_PRGA_WAIT;
      ST_PRGA_WAIT: begin
        if (bus.prga_done) begin
          state_nxt = bus.prga_valid ? ST_FOUND : ST_NEXT_KEY;
        end
      end
      ST_NEXT_KEY:  state_nxt = (key == KEY_MAX) ? ST_FAIL : ST_INIT_GO;
      ST_FOUND:     state_nxt = ST_FOUND;
      ST_FAIL:      state_nxt = ST_FAIL;
      default:      state_nxt = ST_IDLE;
    endcase
`ifdef RC4_PHASE_TIMEOUT_EN
    if (state_nxt == state && wdog_expired &&
        (state == ST_INIT_WAIT || state == ST_KSA_WAIT || state == ST_PRGA_WAIT)) begin
      state_nxt   = ST_FAIL;
      timeout_set = 1'b1;
    end
`endif
  end

  // Moore outputs: start pulses, status levels and the S-port grant all
  // decode from state alone, so only the owning phase can write S.
  always_comb begin
    bus.init_start = 1'b0;
    bus.ksa_start  = 1'b0;
    bus.prga_start = 1'b0;
    bus.s_address  = 8'h00;
    bus.s_data     = 8'h00;
    bus.s_wren     = 1'b0;
    bus.busy       = 1'b1;
    bus.key_found  = 1'b0;
    bus.key_fail   = 1'b0;
    case (state)
      ST_IDLE:    bus.busy = 1'b0;
      ST_INIT_GO: bus.init_start = 1'b1;
      ST_INIT_WAIT: begin
        bus.s_address = bus.init_address;
        bus.s_data    = bus.init_data;
        bus.s_wren    = bus.init_wren;
      end
      ST_KSA_GO:  bus.ksa_start = 1'b1;
      ST_KSA_WAIT: begin
        bus.s_address = bus.ksa_address;
        bus.s_data    = bus.ksa_data;
        bus.s_wren    = bus.ksa_wren;
      end
      ST_PRGA_GO: bus.prga_start = 1'b1;
      ST_PRGA_WAIT: begin
        bus.s_address = bus.prga_address;
        bus.s_data    = bus.prga_data;
        bus.s_wren    = bus.prga_wren;
      end
      ST_FOUND: begin
        bus.busy      = 1'b0;
        bus.key_found = 1'b1;
      end
      ST_FAIL: begin
        bus.busy     = 1'b0;
        bus.key_fail = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.secret_key = key;
`ifdef RC4_PHASE_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`endif

endmodule

// File: tb/tb_rc4_phase_scheduler.sv
`timescale 1ns/1ps
module tb_rc4_phase_scheduler;
  localparam int            KW   = 24;
  localparam logic [KW-1:0] KMAX = 24'd3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rc4_phase_scheduler_if #(.KEY_WIDTH(KW)) bus ();
  rc4_phase_scheduler #(.KEY_WIDTH(KW), .KEY_MAX(KMAX)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model: a search is a sequence of steps per key
  // (0 init go, 1 init run, 2 ksa go, 3 ksa run, 4 prga go, 5 prga run, 6 key advance).
  // Even steps last one cycle, odd steps last until their own done.
  bit            m_active = 1'b0;
  int            m_step   = 0;
  int            m_result = 0;   // 0 none, 1 found, 2 exhausted
  logic [KW-1:0] m_key    = '0;

  always @(posedge clk) begin
    logic d;
    if (reset) begin
      m_active = 1'b0; m_step = 0; m_result = 0; m_key = '0;
    end else if (m_active) begin
      if (m_step == 6) begin
        if (m_key == KMAX) begin m_active = 1'b0; m_result = 2; end
        else begin m_key = m_key + 1'b1; m_step = 0; end
      end else if (m_step % 2 == 0) begin
        m_step++;
      end else begin
        case (m_step / 2)
          0:       d = bus.init_done;
          1:       d = bus.ksa_done;
          default: d = bus.prga_done;
        endcase
        if (d) begin
          if (m_step == 5) begin
            if (bus.prga_valid) begin m_active = 1'b0; m_result = 1; end
            else m_step = 6;
          end else m_step++;
        end
      end
    end else if (m_result == 0 && bus.start) begin
      m_active = 1'b1; m_step = 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  logic [KW-1:0] tried[$];
  always @(negedge clk) begin
    logic [2:0]  e_go;
    logic [16:0] e_port;
    if (cmp_en) begin
      e_go   = {m_active && m_step == 0, m_active && m_step == 2, m_active && m_step == 4};
      e_port = '0;
      if (m_active && m_step == 1) e_port = {bus.init_address, bus.init_data, bus.init_wren};
      if (m_active && m_step == 3) e_port = {bus.ksa_address, bus.ksa_data, bus.ksa_wren};
      if (m_active && m_step == 5) e_port = {bus.prga_address, bus.prga_data, bus.prga_wren};
      chk("start_pulses", {29'd0, bus.init_start, bus.ksa_start, bus.prga_start}, {29'd0, e_go});
      chk("s_port", {15'd0, bus.s_address, bus.s_data, bus.s_wren}, {15'd0, e_port});
      chk("status", {5'd0, bus.secret_key, bus.busy, bus.key_found, bus.key_fail},
          {5'd0, m_key, m_active, m_result == 1, m_result == 2});
      if (bus.init_start) tried.push_back(bus.secret_key);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clr_inputs();
    bus.start = 0;
    bus.init_done = 0; bus.init_address = 0; bus.init_data = 0; bus.init_wren = 0;
    bus.ksa_done  = 0; bus.ksa_address  = 0; bus.ksa_data  = 0; bus.ksa_wren  = 0;
    bus.prga_done = 0; bus.prga_valid = 0;
    bus.prga_address = 0; bus.prga_data = 0; bus.prga_wren = 0;
  endtask

  task automatic rand_inputs();
    bus.start        = ($urandom_range(7) == 0);
    bus.init_done    = ($urandom_range(5) == 0);
    bus.ksa_done     = ($urandom_range(5) == 0);
    bus.prga_done    = ($urandom_range(5) == 0);
    bus.prga_valid   = ($urandom_range(3) == 0);
    bus.init_address = 8'($urandom); bus.init_data = 8'($urandom); bus.init_wren = 1'($urandom);
    bus.ksa_address  = 8'($urandom); bus.ksa_data  = 8'($urandom); bus.ksa_wren  = 1'($urandom);
    bus.prga_address = 8'($urandom); bus.prga_data = 8'($urandom); bus.prga_wren = 1'($urandom);
  endtask

  // Called just after entering init go; returns one cycle after prga done is taken.
  task automatic pass(input logic valid);
    cyc();
    bus.init_done = 1; cyc(); bus.init_done = 0;
    cyc();
    bus.ksa_done = 1;  cyc(); bus.ksa_done = 0;
    cyc();
    bus.prga_done = 1; bus.prga_valid = valid; cyc();
    bus.prga_done = 0; bus.prga_valid = 0;
  endtask

  task automatic do_reset();
    reset = 1; cyc(); cyc(); reset = 0;
  endtask

  initial begin
    clr_inputs();
    reset = 1; cyc(); cmp_en = 1; cyc(); reset = 0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_key", bus.secret_key, 0);
    chk("rst_found_fail", {bus.key_found, bus.key_fail}, 0);
    chk("rst_starts", {bus.init_start, bus.ksa_start, bus.prga_start}, 0);

    // Start; init_wren is already high but must not reach S during the go cycle.
    bus.start = 1; bus.init_wren = 1; bus.init_address = 8'h05; bus.init_data = 8'h3C;
    cyc(); bus.start = 0;
    @(negedge clk);
    chk("go_init_start", bus.init_start, 1);
    chk("go_busy", bus.busy, 1);
    chk("go_key", bus.secret_key, 0);
    chk("go_s_wren", bus.s_wren, 0);

    // Init owns S; KSA write and a stray ksa_done are ignored.
    bus.ksa_wren = 1; bus.ksa_address = 8'hAA; bus.ksa_done = 1;
    cyc();
    @(negedge clk);
    chk("init_grant", {bus.s_address, bus.s_data, bus.s_wren}, {8'h05, 8'h3C, 1'b1});
    cyc();
    @(negedge clk);
    chk("stale_ksa_done", {bus.ksa_start, bus.s_address}, {1'b0, 8'h05});
    bus.ksa_done = 0; bus.init_done = 1; cyc(); bus.init_done = 0;
    @(negedge clk);
    chk("ksa_go", {bus.ksa_start, bus.s_wren}, {1'b1, 1'b0});
    cyc();
    @(negedge clk);
    chk("ksa_grant", {bus.s_address, bus.s_wren}, {8'hAA, 1'b1});
    bus.ksa_done = 1; cyc(); bus.ksa_done = 0;
    @(negedge clk);
    chk("prga_go", bus.prga_start, 1);
    cyc();
    bus.prga_done = 1; bus.prga_valid = 0; cyc(); bus.prga_done = 0;
    @(negedge clk);
    chk("next_key_hold", {bus.secret_key, bus.busy}, {24'd0, 1'b1});
    cyc();
    @(negedge clk);
    chk("retry_init_start", {bus.init_start, bus.secret_key}, {1'b1, 24'd1});
    pass(1);
    @(negedge clk);
    chk("found", {bus.key_found, bus.secret_key, bus.busy}, {1'b1, 24'd1, 1'b0});
    chk("model_found", {m_result, 8'd0, m_key}, {32'd1, 8'd0, 24'd1});
    bus.start = 1; cyc(); bus.start = 0;
    @(negedge clk);
    chk("found_ignores_start", {bus.init_start, bus.key_found}, 2'b01);

    // Exhaustive search with every key rejected.
    clr_inputs(); do_reset(); tried.delete();
    bus.start = 1; cyc(); bus.start = 0;
    for (int k = 0; k < 4; k++) begin
      pass(0);
      cyc();
    end
    @(negedge clk);
    chk("exhaust_fail", {bus.key_fail, bus.key_found, bus.secret_key, bus.busy}, {1'b1, 1'b0, 24'd3, 1'b0});
    chk("model_exhaust", m_result, 2);
    chk("keys_tried", tried.size(), 4);
    for (int k = 0; k < tried.size() && k < 4; k++) chk("key_order", tried[k], k);

    // Reset while KSA runs on key 2.
    clr_inputs(); do_reset();
    bus.start = 1; cyc(); bus.start = 0;
    pass(0); cyc(); pass(0); cyc();
    cyc(); bus.init_done = 1; cyc(); bus.init_done = 0; cyc();
    @(negedge clk);
    chk("pre_reset_ksa", {bus.secret_key, bus.s_wren}, {24'd2, 1'b0});
    bus.init_wren = 1; bus.ksa_wren = 1; bus.prga_wren = 1;
    @(negedge clk);
    chk("pre_reset_grant", bus.s_wren, 1);
    reset = 1; cyc(); reset = 0;
    @(negedge clk);
    chk("mid_reset", {bus.secret_key, bus.busy, bus.init_start, bus.ksa_start, bus.prga_start, bus.s_wren},
        {24'd0, 5'd0});

    // Randomized searches checked cycle by cycle by the model.
    for (int r = 0; r < 25; r++) begin
      int  c;
      bit  done_seen;
      clr_inputs(); do_reset();
      done_seen = 0;
      c = 0;
      while (c < 2000 && !done_seen) begin
        rand_inputs();
        if ($urandom_range(299) == 0) reset = 1;
        cyc();
        reset = 0;
        if (bus.key_found || bus.key_fail) done_seen = 1;
        c++;
      end
      for (int t = 0; t < 5; t++) begin rand_inputs(); cyc(); end
      chk("random_run_terminates", done_seen, 1);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
